// File: rtl/deser_1x8.sv
// Serial-to-parallel deserializer: gathers eight accepted bits into a byte and
// offers it through a one-entry holding register with a sticky overrun flag.
module deser_1x8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clear,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [2:0] bit_count,
  output logic       overrun
);

  // Handshake: a byte moves downstream on a rising edge where data_valid=1 and
  // data_ready=1; data_out is held stable for as long as data_valid=1.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  hold_state_t state_q, state_d;
  logic [7:0]  sr;
  logic [7:0]  sr_shift;
  logic [2:0]  cnt;
  logic        accept;
  logic        complete;
  logic        load;
  logic        drop;

  assign accept    = bit_valid & ~clear;
  assign complete  = accept & (cnt == 3'd7);
  assign sr_shift  = MSB_FIRST ? {sr[6:0], bit_in} : {bit_in, sr[7:1]};
  assign bit_count = cnt;
  // The state register is the data_valid flag itself.
  assign data_valid = (state_q == FULL);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete && data_ready) begin
          load = 1'b1;
        end else if (data_ready) begin
          state_d = EMPTY;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_out <= 8'h00;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_out <= sr_shift;
      end
    end
  end

  // Clear flushes the partial byte and overrun only; the holding register is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= 8'h00;
      cnt     <= 3'd0;
      overrun <= 1'b0;
    end else if (clear) begin
      sr      <= 8'h00;
      cnt     <= 3'd0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        sr  <= sr_shift;
        cnt <= cnt + 3'd1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deser_1x8.sv
// Directed bench for deser_1x8: one instance per bit order, driven in parallel
// from a vector table plus hand-written reset, clear and handshake sequences.
module tb_deser_1x8;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;
  logic       data_ready;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [2:0] m_cnt, l_cnt;
  logic       m_ov, l_ov;

  int checks = 0;
  int errors = 0;
  logic [2:0] cnt_m = 3'd0;

  deser_1x8 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .data_out(m_data), .data_valid(m_valid), .data_ready(data_ready),
    .bit_count(m_cnt), .overrun(m_ov)
  );

  deser_1x8 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .data_out(l_data), .data_valid(l_valid), .data_ready(data_ready),
    .bit_count(l_cnt), .overrun(l_ov)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         max_gap;
    logic       rdy;
    logic       consume;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    logic       exp_v;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] em, input logic [7:0] el,
                         input logic ev, input logic eo, input logic [2:0] ec);
    chk({tag, " msb data_out"}, m_data, em);
    chk({tag, " lsb data_out"}, l_data, el);
    chk({tag, " msb data_valid"}, {7'd0, m_valid}, {7'd0, ev});
    chk({tag, " lsb data_valid"}, {7'd0, l_valid}, {7'd0, ev});
    chk({tag, " msb overrun"}, {7'd0, m_ov}, {7'd0, eo});
    chk({tag, " lsb overrun"}, {7'd0, l_ov}, {7'd0, eo});
    chk({tag, " msb bit_count"}, {5'd0, m_cnt}, {5'd0, ec});
    chk({tag, " lsb bit_count"}, {5'd0, l_cnt}, {5'd0, ec});
  endtask

  // driver: sends b[7] first; data_ready may be raised on the completing edge
  task automatic send_bits(input logic [7:0] b, input int nbits, input int max_gap,
                           input logic rdy_done);
    for (int i = 7; i > 7 - nbits; i--) begin
      bit_in     = b[i];
      bit_valid  = 1'b1;
      data_ready = (i == 0) ? rdy_done : 1'b0;
      step();
      bit_valid  = 1'b0;
      data_ready = 1'b0;
      cnt_m      = cnt_m + 3'd1;
      chk("bit_count msb", {5'd0, m_cnt}, {5'd0, cnt_m});
      chk("bit_count lsb", {5'd0, l_cnt}, {5'd0, cnt_m});
      for (int g = 0, n = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0; g < n; g++) begin
        step();
        chk("gap bit_count", {5'd0, m_cnt}, {5'd0, cnt_m});
      end
    end
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; data_ready = 1'b0;

    vecs[0] = '{8'hA5, 0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 5, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 0, 1'b0, 1'b0, 8'h11, 8'h88, 1'b1, 1'b0};
    vecs[3] = '{8'h22, 0, 1'b0, 1'b0, 8'h11, 8'h88, 1'b1, 1'b1};

    #12;
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    rst = 1'b0;
    repeat (3) step();
    chk_all("idle", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

    // first byte must not be visible until the 8th bit is taken
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        send_bits(vecs[k].data, 7, 0, 1'b0);
        chk("pre-completion valid", {7'd0, m_valid}, 8'h00);
        bit_in = vecs[k].data[0]; bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        cnt_m = cnt_m + 3'd1;
      end else begin
        send_bits(vecs[k].data, 8, vecs[k].max_gap, vecs[k].rdy);
      end
      chk_all($sformatf("vec%0d", k), vecs[k].exp_m, vecs[k].exp_l,
              vecs[k].exp_v, vecs[k].exp_ov, 3'd0);
      if (vecs[k].consume) begin
        repeat (2) step();
        chk("hold msb", m_data, vecs[k].exp_m);
        chk("hold valid", {7'd0, m_valid}, 8'h01);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        chk_all($sformatf("vec%0d consumed", k), vecs[k].exp_m, vecs[k].exp_l,
                1'b0, 1'b0, 3'd0);
      end
    end

    // clear mid-byte, with bit_valid on the same edge, while 8'h11 is held and overrun set
    send_bits(8'hE0, 3, 0, 1'b0);
    chk("partial count", {5'd0, m_cnt}, 8'd3);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    clear = 1'b0; bit_valid = 1'b0;
    cnt_m = 3'd0;
    chk_all("after clear", 8'h11, 8'h88, 1'b1, 1'b0, 3'd0);
    send_bits(8'hF0, 8, 0, 1'b1);
    chk_all("F0 after clear", 8'hF0, 8'h0F, 1'b1, 1'b0, 3'd0);

    // back-to-back: completion and consume on one edge
    send_bits(8'h33, 8, 0, 1'b1);
    chk_all("33 swap", 8'h33, 8'hCC, 1'b1, 1'b0, 3'd0);
    data_ready = 1'b1;
    step();
    chk_all("33 consumed", 8'h33, 8'hCC, 1'b0, 1'b0, 3'd0);
    step();
    data_ready = 1'b0;
    chk_all("ready while empty", 8'h33, 8'hCC, 1'b0, 1'b0, 3'd0);

    // clear on a consume edge still completes the handshake
    send_bits(8'h0F, 8, 0, 1'b0);
    chk_all("0F held", 8'h0F, 8'hF0, 1'b1, 1'b0, 3'd0);
    clear = 1'b1; data_ready = 1'b1;
    step();
    clear = 1'b0; data_ready = 1'b0;
    chk_all("clear+consume", 8'h0F, 8'hF0, 1'b0, 1'b0, 3'd0);

    // asynchronous reset mid-byte with a byte held
    send_bits(8'h55, 8, 0, 1'b0);
    chk_all("55 held", 8'h55, 8'hAA, 1'b1, 1'b0, 3'd0);
    send_bits(8'hFF, 5, 0, 1'b0);
    chk("cnt before rst", {5'd0, m_cnt}, 8'd5);
    #2 rst = 1'b1;
    #1;
    chk_all("async rst", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    #3 rst = 1'b0;
    cnt_m = 3'd0;
    repeat (4) step();
    chk_all("post-rst idle", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

    // sr was zeroed by reset: a fresh byte comes out intact
    send_bits(8'hC3, 8, 2, 1'b0);
    chk_all("C3 after rst", 8'hC3, 8'hC3, 1'b1, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deser_1x8.md
# deser_1x8

Serial-to-parallel deserializer for the Hack elementary-logic library. It collects eight single-bit samples into a byte and presents that byte in a one-entry holding register. A valid/ready handshake passes the byte downstream, and a sticky overrun flag records any byte dropped while the holding register was still occupied. It feeds bit-serial peripheral inputs, such as the keyboard path, into byte-wide logic.

## Interface
- MSB_FIRST, 1, bit order:
  - 1: the first accepted bit ends in data_out[7].
  - 0: the first accepted bit ends in data_out[0].
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data sample.
- bit_valid  input  1  bit_in is accepted on this edge. There is no backpressure, so every valid bit is taken.
- clear  input  1  synchronous flush of the partial byte and the overrun flag.
- data_out  output  8  holding-register byte; stable while data_valid=1.
- data_valid  output  1  holding register full.
- data_ready  input  1  consumer accepts data_out on an edge where data_valid=1.
- bit_count  output  3  number of bits in the partial byte (0..7).
- overrun  output  1  sticky; set when a completed byte is dropped.

## Operation
- Shift register sr[7:0] and counter cnt[2:0]; bit_count = cnt.
- Accepted bit (bit_valid=1, clear=0):
  - MSB_FIRST=1: sr <= {sr[6:0], bit_in}.
  - MSB_FIRST=0: sr <= {bit_in, sr[7:1]}.
  - cnt increments, wrapping 7 -> 0.
- Byte completion: a bit accepted while cnt=7. The completed byte is the shifted value including that bit. cnt returns to 0 and sr is not cleared; it is overwritten by the next 8 bits.
- Holding register states:
  - EMPTY (data_valid=0): completion loads data_out and moves to FULL.
  - FULL, completion and consume on the same edge (data_ready=1): load the new byte and stay FULL.
  - FULL, consume without completion: move to EMPTY; data_out keeps its old value.
  - FULL, completion without consume: drop the new byte, keep data_out, set overrun=1.
- overrun stays at 1 until rst or clear.
- clear=1:
  - cnt <= 0, sr <= 0, overrun <= 0.
  - bit_valid on the same edge is ignored.
  - data_out, data_valid and the handshake are unaffected, so a consume on the same edge still completes.
- data_ready while data_valid=0 has no effect.

## Timing
- Reset values, applied asynchronously: data_out=8'h00, data_valid=0, bit_count=0, overrun=0, sr=0.
- rst mid-byte discards the partial byte. A held byte is lost.
- Latency: after the edge that accepts the 8th bit, data_valid=1 and data_out are visible on the following cycle (one register stage).
- Throughput: one bit per cycle sustained. A byte completes every 8 cycles.
- The consumer must accept within 8 accepted bits of data_valid rising, or overrun follows.
- Gaps (bit_valid=0) hold cnt and sr unchanged, for any length.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Stimulus: assert rst asynchronously mid-cycle with cnt=5 and data_valid=1.
  - Required: outputs go to 00/0/0/0 immediately; after release with no bit_valid, all stay at reset values.
- MSB_FIRST=1 byte:
  - Stimulus: bits 1,0,1,0,0,1,0,1 on consecutive edges, data_ready=0.
  - Required: data_out=8'hA5, data_valid=1 one cycle after the 8th bit; bit_count reads 0; holds until data_ready=1, then data_valid=0.
- MSB_FIRST=0 byte:
  - Stimulus: the same bit sequence.
  - Required: data_out=8'hA5 (first bit in bit 0).
- Gapped input:
  - Stimulus: bits of 8'h3C with random bit_valid gaps of 0..5 cycles.
  - Required: data_out=8'h3C; bit_count steps only on valid edges.
- Overrun and back-to-back:
  - Stimulus (a): send 8'h11 then 8'h22 with data_ready=0.
  - Required (a): data_out stays 8'h11 and overrun=1 after the 16th bit.
  - Stimulus (b): send 8'h33 with data_ready=1 on the completion edge.
  - Required (b): data_out=8'h33, data_valid stays 1, no new overrun.
- Clear mid-byte:
  - Stimulus: 3 bits, then clear=1 together with bit_valid=1, then 8 bits of 8'hF0.
  - Required: bit_count=0 after clear, overrun=0, next data_out=8'hF0; a held byte survives the clear.
